// File: rtl/f_fetch_unit_if.sv
// Instruction-memory handshake between the fetch unit and instruction memory.
//   imem_req   : fetch request valid (fetch side drives)
//   imem_addr  : fetch address, held while imem_req=1 and imem_ready=0
//   imem_ready : memory completes the request this cycle (memory side drives)
//   imem_rdata : instruction word, valid with imem_ready
interface f_fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rdata
    );
endinterface

// File: rtl/f_fetch_unit.sv
// Fetch-stage producer for the F/D pipeline register.
// Owns the fetch PC, issues requests to instruction memory, and presents one
// instruction at a time on F_PC/F_Command/F_Valid. A one-entry hold buffer
// absorbs downstream stalls; redirect loads a new PC and squashes the current
// fetch.
//   clk         : clock, all state on posedge
//   reset       : asynchronous, active-low
//   fd_en       : F/D register captures F_PC/F_Command at this posedge
//   redirect    : load redirect_pc (word aligned) as next fetch PC
//   redirect_pc : redirect target
//   imem        : instruction-memory handshake (master side)
//   F_PC        : address of the presented instruction
//   F_Command   : presented instruction, 0 when F_Valid=0
//   F_Valid     : F_Command is a real instruction
module f_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  fd_en,
    input  logic                  redirect,
    input  logic [31:0]           redirect_pc,
    f_fetch_unit_if.master        imem,
    output logic [31:0]           F_PC,
    output logic [31:0]           F_Command,
    output logic                  F_Valid
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DROP  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] req_addr_q, req_addr_d;
    logic [31:0] buf_instr_q, buf_instr_d;
    logic [31:0] buf_pc_q, buf_pc_d;

    logic [31:0] target_pc;
    logic [31:0] pc_plus4;

    assign target_pc = {redirect_pc[31:2], 2'b00};
    assign pc_plus4  = pc_q + 32'd4;

    // Output decode. The reset term keeps the request and bypass quiet while
    // reset is asserted, since state already reads FETCH during reset.
    always_comb begin
        imem.imem_req  = 1'b0;
        imem.imem_addr = pc_q;
        F_Valid        = 1'b0;
        F_Command      = '0;
        F_PC           = pc_q;
        case (state_q)
            FETCH: begin
                imem.imem_req = reset;
                if (reset && imem.imem_ready && !redirect) begin
                    F_Valid   = 1'b1;
                    F_Command = imem.imem_rdata;
                end
            end
            HOLD: begin
                F_PC = buf_pc_q;
                if (!redirect) begin
                    F_Valid   = 1'b1;
                    F_Command = buf_instr_q;
                end
            end
            DROP: begin
                imem.imem_req  = reset;
                imem.imem_addr = req_addr_q;
            end
            default: begin
                imem.imem_req = 1'b0;
            end
        endcase
    end

    // Next-state logic; redirect wins over every other event.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        req_addr_d  = req_addr_q;
        buf_instr_d = buf_instr_q;
        buf_pc_d    = buf_pc_q;
        case (state_q)
            FETCH: begin
                if (redirect) begin
                    pc_d        = target_pc;
                    buf_instr_d = '0;
                    buf_pc_d    = '0;
                    if (!imem.imem_ready) begin
                        // Request still outstanding: finish it, then discard.
                        req_addr_d = pc_q;
                        state_d    = DROP;
                    end
                end else if (imem.imem_ready) begin
                    pc_d = pc_plus4;
                    if (!fd_en) begin
                        buf_instr_d = imem.imem_rdata;
                        buf_pc_d    = pc_q;
                        state_d     = HOLD;
                    end
                end
            end
            HOLD: begin
                if (redirect) begin
                    pc_d        = target_pc;
                    buf_instr_d = '0;
                    buf_pc_d    = '0;
                    state_d     = FETCH;
                end else if (fd_en) begin
                    state_d = FETCH;
                end
            end
            DROP: begin
                if (redirect) begin
                    pc_d        = target_pc;
                    buf_instr_d = '0;
                    buf_pc_d    = '0;
                end else if (imem.imem_ready) begin
                    state_d = FETCH;
                end
            end
            default: begin
                state_d = FETCH;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= FETCH;
            pc_q        <= RESET_PC;
            req_addr_q  <= '0;
            buf_instr_q <= '0;
            buf_pc_q    <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            req_addr_q  <= req_addr_d;
            buf_instr_q <= buf_instr_d;
            buf_pc_q    <= buf_pc_d;
        end
    end

endmodule

// File: tb/tb_f_fetch_unit.sv
// Self-checking bench for f_fetch_unit: directed stimulus, an instruction-
// stream model checked every cycle, literal checks of the accepted stream,
// and a second instance with a wrapping reset PC.
module tb_f_fetch_unit;

    logic        clk;
    logic        reset;
    logic        fd_en;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        ready;
    logic [31:0] F_PC, F_Command;
    logic        F_Valid;

    logic [31:0] F_PC2, F_Command2;
    logic        F_Valid2;

    int unsigned n_vec  = 0;
    int unsigned n_miss = 0;

    f_fetch_unit_if m_if ();
    f_fetch_unit_if m_if2 ();

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    assign m_if.imem_ready  = ready;
    assign m_if.imem_rdata  = mem_word(m_if.imem_addr);
    assign m_if2.imem_ready = 1'b1;
    assign m_if2.imem_rdata = mem_word(m_if2.imem_addr);

    f_fetch_unit #(.RESET_PC(32'h0000_3000)) u_dut (
        .clk         (clk),
        .reset       (reset),
        .fd_en       (fd_en),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem        (m_if.master),
        .F_PC        (F_PC),
        .F_Command   (F_Command),
        .F_Valid     (F_Valid)
    );

    f_fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) u_dut_wrap (
        .clk         (clk),
        .reset       (reset),
        .fd_en       (1'b1),
        .redirect    (1'b0),
        .redirect_pc (32'h0),
        .imem        (m_if2.master),
        .F_PC        (F_PC2),
        .F_Command   (F_Command2),
        .F_Valid     (F_Valid2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Instruction-stream model: next address to present, whether a stalled
    // instruction is being held, and whether a stale request is being drained.
    logic [31:0] exp_next      = 32'h0000_3000;
    logic        exp_hold      = 1'b0;
    logic [31:0] exp_held_pc   = '0;
    logic        exp_squash    = 1'b0;
    logic [31:0] exp_squash_addr = '0;

    logic [31:0] acc_log[$];
    logic [31:0] wrap_log[$];

    always @(negedge clk) begin : cmp
        logic        e_req, e_val;
        logic [31:0] e_addr, e_cmd, e_pc;
        e_addr = '0;
        e_pc   = '0;
        if (!reset) begin
            e_req = 1'b0; e_val = 1'b0; e_cmd = '0; e_pc = 32'h0000_3000;
        end else if (exp_hold) begin
            e_req = 1'b0;
            e_val = !redirect;
            e_pc  = exp_held_pc;
            e_cmd = e_val ? mem_word(exp_held_pc) : '0;
        end else if (exp_squash) begin
            e_req = 1'b1; e_addr = exp_squash_addr; e_val = 1'b0; e_cmd = '0;
        end else begin
            e_req  = 1'b1;
            e_addr = exp_next;
            e_val  = ready && !redirect;
            e_pc   = exp_next;
            e_cmd  = e_val ? mem_word(exp_next) : '0;
        end

        chk("imem_req", {31'b0, m_if.imem_req}, {31'b0, e_req});
        if (e_req) chk("imem_addr", m_if.imem_addr, e_addr);
        chk("F_Valid", {31'b0, F_Valid}, {31'b0, e_val});
        chk("F_Command", F_Command, e_cmd);
        if (e_val || !reset) chk("F_PC", F_PC, e_pc);

        if (reset && F_Valid && fd_en) acc_log.push_back(F_PC);
        if (reset && F_Valid2 && wrap_log.size() < 3) wrap_log.push_back(F_PC2);

        // Advance the model to the state after the coming posedge.
        if (!reset) begin
            exp_next = 32'h0000_3000; exp_hold = 1'b0; exp_squash = 1'b0;
        end else if (redirect) begin
            if (exp_hold) exp_hold = 1'b0;
            else if (!exp_squash && !ready) begin
                exp_squash = 1'b1; exp_squash_addr = exp_next;
            end
            exp_next = redirect_pc & ~32'd3;
        end else if (exp_hold) begin
            if (fd_en) exp_hold = 1'b0;
        end else if (exp_squash) begin
            if (ready) exp_squash = 1'b0;
        end else if (ready) begin
            if (!fd_en) begin
                exp_hold = 1'b1; exp_held_pc = exp_next;
            end
            exp_next = exp_next + 32'd4;
        end
    end

    task automatic step(input logic rdy, input logic fe, input logic rd,
                        input logic [31:0] rp, input logic rst);
        @(posedge clk);
        #1;
        ready = rdy; fd_en = fe; redirect = rd; redirect_pc = rp; reset = rst;
        @(negedge clk);
        #1;
    endtask

    logic [31:0] exp_acc[8];
    logic [31:0] exp_wrap[3];

    initial begin
        reset = 1'b0; ready = 1'b1; fd_en = 1'b1; redirect = 1'b0; redirect_pc = '0;
        exp_acc  = '{32'h3000, 32'h3004, 32'h3008, 32'h3000, 32'h3004,
                     32'h4000, 32'h5000, 32'h6008};
        exp_wrap = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000};

        step(1, 1, 0, 0, 0);
        step(1, 1, 0, 0, 0);
        // zero-wait streaming
        step(1, 1, 0, 0, 1); chk("first_pc", F_PC, 32'h3000);
        step(1, 1, 0, 0, 1); chk("second_pc", F_PC, 32'h3004);
        step(1, 1, 0, 0, 1);
        // reset during an outstanding request
        step(0, 1, 0, 0, 1);
        step(0, 1, 0, 0, 0);
        // two wait states
        step(0, 1, 0, 0, 1); chk("wait_addr0", m_if.imem_addr, 32'h3000);
        step(0, 1, 0, 0, 1); chk("wait_addr1", m_if.imem_addr, 32'h3000);
        step(1, 1, 0, 0, 1); chk("wait_valid", {31'b0, F_Valid}, 32'd1);
        // stall for three cycles at 0x3004
        step(1, 0, 0, 0, 1);
        step(1, 0, 0, 0, 1); chk("hold_pc", F_PC, 32'h3004);
        step(1, 0, 0, 0, 1); chk("hold_req", {31'b0, m_if.imem_req}, 32'd0);
        step(1, 1, 0, 0, 1);
        // redirect with an outstanding request to 0x3008
        step(0, 1, 1, 32'h4003, 1); chk("redir_valid", {31'b0, F_Valid}, 32'd0);
        step(0, 1, 0, 0, 1); chk("drop_addr", m_if.imem_addr, 32'h3008);
        step(1, 1, 0, 0, 1); chk("drop_valid", {31'b0, F_Valid}, 32'd0);
        step(1, 1, 0, 0, 1); chk("target_addr", m_if.imem_addr, 32'h4000);
        // redirect while holding
        step(1, 0, 0, 0, 1);
        step(1, 1, 1, 32'h5000, 1); chk("hold_redir_valid", {31'b0, F_Valid}, 32'd0);
        step(1, 1, 0, 0, 1); chk("hold_target", m_if.imem_addr, 32'h5000);
        // redirect on a completing fetch
        step(1, 1, 1, 32'h600B, 1);
        step(1, 1, 0, 0, 1); chk("fetch_redir_pc", F_PC, 32'h6008);
        step(0, 1, 0, 0, 1);

        chk("acc_count", acc_log.size(), 32'd8);
        for (int i = 0; i < 8; i++) begin
            if (i < acc_log.size()) chk("acc_pc", acc_log[i], exp_acc[i]);
        end
        chk("wrap_count", wrap_log.size(), 32'd3);
        for (int i = 0; i < 3; i++) begin
            if (i < wrap_log.size()) chk("wrap_pc", wrap_log[i], exp_wrap[i]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/f_fetch_unit.md
# f_fetch_unit

Fetch-stage producer for the F/D pipeline register. It owns the fetch PC, talks to instruction memory over a request/ready handshake, and presents one instruction at a time as F_PC/F_Command/F_Valid. A one-entry hold buffer absorbs downstream stalls, and a redirect port loads a new PC for branches and jumps. It sits between instruction memory and the F/D register, and shares that register's enable so both sides agree on each transfer.

## Interface
- RESET_PC, 32'h0000_3000, first fetch address after reset
- clk  in  1  clock, all state updates on posedge
- reset  in  1  asynchronous, active-low; 0 = reset
- fd_en  in  1  F/D register enable; 1 = D captures F_PC/F_Command at this posedge
- redirect  in  1  load redirect_pc as next fetch PC; squashes current fetch
- redirect_pc  in  32  target address; bits [1:0] are forced to 0 internally
- imem_req  out  1  fetch request valid
- imem_addr  out  32  fetch address, stable while imem_req=1 and imem_ready=0
- imem_ready  in  1  memory completes the request this cycle; imem_rdata valid
- imem_rdata  in  32  instruction word
- F_PC  out  32  address of the presented instruction
- F_Command  out  32  presented instruction; 32'h0 (nop) when F_Valid=0
- F_Valid  out  1  F_Command is a real instruction

## Operation
- Registers: pc, req_addr, buf_instr, buf_pc, state (FETCH, HOLD, DROP).
- A transfer happens at a posedge where imem_req=1 and imem_ready=1.
- FETCH:
  - Drives imem_req=1 and imem_addr=pc.
  - If imem_ready=1 and redirect=0, it bypasses combinationally: F_Valid=1, F_Command=imem_rdata, F_PC=pc.
  - If that bypass sees fd_en=1: pc<=pc+4, stay in FETCH.
  - If that bypass sees fd_en=0: buf_instr<=imem_rdata, buf_pc<=pc, pc<=pc+4, go to HOLD.
  - If imem_ready=0, stay in FETCH with the same address.
- HOLD:
  - Drives imem_req=0, F_Valid=1, F_Command=buf_instr, F_PC=buf_pc.
  - On fd_en=1, go to FETCH.
  - On fd_en=0, stay in HOLD with outputs unchanged.
- DROP:
  - Drives imem_req=1, imem_addr=req_addr (the old address).
  - Drives F_Valid=0, F_Command=0, F_PC=pc.
  - On imem_ready=1, discard the data and go to FETCH.
- Redirect has priority over all other events and forces F_Valid=0 in the same cycle. At the posedge, pc<=redirect_pc & ~3, and the hold buffer is invalidated.
  - FETCH with imem_ready=0: req_addr<=pc, go to DROP. The outstanding request is completed, then discarded.
  - FETCH with imem_ready=1: the transfer completes, the data is discarded, go to FETCH.
  - HOLD: buffered instruction dropped, go to FETCH.
  - DROP: stay in DROP; pc is updated again, and req_addr is unchanged.
- Delay slots are not handled here. The hazard/branch controller asserts redirect only after the delay-slot instruction has been accepted (F_Valid=1 and fd_en=1).
- With F_Valid=0 the F/D register may still capture. It receives a nop bubble.
- pc+4 is computed modulo 2^32, so 32'hFFFF_FFFC wraps to 0.
- imem_req = (state is FETCH or DROP) AND reset.

## Timing
- Reset (reset=0) values:
  - pc=RESET_PC, state=FETCH, buffers 0.
  - imem_req=0, F_Valid=0, F_Command=0, F_PC=RESET_PC.
- The first request is in the first cycle after reset deasserts.
- With zero-wait memory and fd_en=1 there is zero latency from ready to F_Valid. Throughput is 1 instruction/cycle.
- A stall costs nothing extra: on fd_en rising while in HOLD, the next request is issued in the following cycle.
- Redirect to first target fetch:
  - From FETCH or HOLD: the next request is for the target in the cycle after the redirect edge.
  - From an outstanding request: the target is fetched one cycle after the old request's imem_ready.
- Reset asserted mid-request: the state is abandoned immediately. The memory side must tolerate the dropped request.

## Test plan
- Reset then zero-wait memory (ready=1 always), fd_en=1 -> F_PC reads 0x3000, 0x3004, 0x3008 on consecutive cycles, F_Valid=1 each cycle, imem_addr equals F_PC.
- Ready delayed 2 cycles per request -> imem_addr holds 0x3000 for 3 cycles, F_Valid=1 only in the ready cycle, the next request is 0x3004.
- fd_en=0 for 3 cycles while ready=1 at 0x3004 -> HOLD; F_Command/F_PC stay at the 0x3004 word and imem_req=0; after fd_en=1, the next fetch is 0x3008.
- redirect=1 with redirect_pc=0x4003 while a request to 0x3008 is outstanding (ready=0) -> F_Valid=0; imem_addr stays 0x3008 until ready; that data is never presented; the next request is 0x4000.
- redirect while in HOLD -> the held instruction is dropped (no F_Valid), and the next request is to the target the following cycle.
- RESET_PC=32'hFFFF_FFF8 with zero-wait memory -> fetch order FFFF_FFF8, FFFF_FFFC, 0000_0000.
